// File: rtl/song_sequencer_ctrl.sv
// Song ROM sequencer with beat timebase, play/pause/stop control and
// live-keyboard override of the shared tone-generator note bus.
module song_sequencer_ctrl #(
  parameter int unsigned       NOTE_W   = 4,
  parameter int unsigned       ADDR_W   = 6,
  parameter int unsigned       BEAT_DIV = 12500000,
  parameter logic [NOTE_W-1:0] END_CODE = 4'hF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              play,
  input  logic              stop,
  input  logic              loop_en,
  input  logic              key_valid,
  input  logic [NOTE_W-1:0] key_note,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [NOTE_W-1:0] rom_data,
  output logic [NOTE_W-1:0] note_out,
  output logic              src_manual,
  output logic              busy,
  output logic              beat
);

  localparam int unsigned      CNT_W = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(BEAT_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH_A = 3'd1,
    S_FETCH_D = 3'd2,
    S_PLAY    = 3'd3,
    S_PAUSE   = 3'd4
  } state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [NOTE_W-1:0] cur_note, cur_note_d;
  logic [ADDR_W-1:0] addr_d;
  logic [NOTE_W-1:0] note_d;
  logic              src_d;
  logic              busy_d;
  logic              beat_d;

  // State, sequencing registers and registered outputs
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= S_IDLE;
      cnt        <= '0;
      cur_note   <= '0;
      rom_addr   <= '0;
      note_out   <= '0;
      src_manual <= 1'b0;
      busy       <= 1'b0;
      beat       <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      cur_note   <= cur_note_d;
      rom_addr   <= addr_d;
      note_out   <= note_d;
      src_manual <= src_d;
      busy       <= busy_d;
      beat       <= beat_d;
    end
  end

  // Next-state, sequencing and note-bus arbitration
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    cur_note_d = cur_note;
    addr_d     = rom_addr;
    beat_d     = 1'b0;
    note_d     = '0;
    src_d      = 1'b0;
    busy_d     = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (play && !stop) begin
          cur_note_d = '0;
          state_d    = S_FETCH_A;
        end
      end
      S_FETCH_A: state_d = S_FETCH_D;
      S_FETCH_D: begin
        if (rom_data == END_CODE) begin
          // An END at address 0 is an empty song: never loop on it.
          addr_d  = '0;
          state_d = (loop_en && (rom_addr != '0)) ? S_FETCH_A : S_IDLE;
        end else begin
          cur_note_d = rom_data;
          cnt_d      = '0;
          state_d    = S_PLAY;
        end
      end
      S_PLAY: begin
        // play wins over terminal count; the held count fires on resume
        if (play) begin
          state_d = S_PAUSE;
        end else if (cnt == CNT_TC) begin
          beat_d  = 1'b1;
          addr_d  = rom_addr + ADDR_W'(1);
          cnt_d   = '0;
          state_d = S_FETCH_A;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      S_PAUSE: begin
        if (play) state_d = S_PLAY;
      end
      default: state_d = S_IDLE;
    endcase

    if (stop && (state != S_IDLE)) begin
      state_d = S_IDLE;
      addr_d  = '0;
      cnt_d   = '0;
      beat_d  = 1'b0;
    end

    busy_d = (state_d != S_IDLE);

    if (key_valid) begin
      note_d = key_note;
      src_d  = 1'b1;
    end else if ((state_d == S_PLAY) || (state_d == S_FETCH_A) || (state_d == S_FETCH_D)) begin
      note_d = cur_note_d;
    end
  end

endmodule

// File: tb/tb_song_sequencer_ctrl.sv
// Randomised and directed bench for song_sequencer_ctrl against a
// step/position reference model of the song player.
module tb_song_sequencer_ctrl;

  localparam int unsigned NOTE_W   = 4;
  localparam int unsigned ADDR_W   = 2;
  localparam int unsigned BEAT_DIV = 4;
  localparam int          DEPTH    = 4;
  localparam logic [3:0]  END_C    = 4'hF;
  localparam logic [3:0]  N_E      = 4'h5;
  localparam logic [3:0]  N_F      = 4'h6;
  localparam logic [3:0]  N_G      = 4'h9;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic              play = 1'b0;
  logic              stop = 1'b0;
  logic              loop_en = 1'b0;
  logic              key_valid = 1'b0;
  logic [NOTE_W-1:0] key_note = '0;
  logic [ADDR_W-1:0] rom_addr;
  logic [NOTE_W-1:0] rom_data;
  logic [NOTE_W-1:0] note_out;
  logic              src_manual;
  logic              busy;
  logic              beat;

  logic [NOTE_W-1:0] rom [DEPTH];

  int checks = 0;
  int errors = 0;

  song_sequencer_ctrl #(
    .NOTE_W  (NOTE_W),
    .ADDR_W  (ADDR_W),
    .BEAT_DIV(BEAT_DIV),
    .END_CODE(END_C)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .play      (play),
    .stop      (stop),
    .loop_en   (loop_en),
    .key_valid (key_valid),
    .key_note  (key_note),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .note_out  (note_out),
    .src_manual(src_manual),
    .busy      (busy),
    .beat      (beat)
  );

  always #5 CLK = ~CLK;

  // Synchronous song ROM: data valid one cycle after the address
  always @(posedge CLK) rom_data <= rom[rom_addr];

  // Reference model: idle / running / paused, plus the position inside
  // the current step (0,1 = fetch cycles, 2..BEAT_DIV+1 = sounding cycles).
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  int         m_mode = M_IDLE;
  int         m_addr = 0;
  int         m_pos  = 0;
  logic [3:0] m_note = '0;
  logic       exp_beat = 1'b0;
  logic [3:0] exp_note = '0;
  logic       exp_src = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_update();
    exp_beat = 1'b0;
    if (RESET) begin
      m_mode = M_IDLE; m_addr = 0; m_pos = 0; m_note = '0;
    end else if (m_mode != M_IDLE && stop) begin
      m_mode = M_IDLE; m_addr = 0; m_pos = 0;
    end else if (m_mode == M_IDLE) begin
      if (play && !stop) begin
        m_mode = M_RUN; m_pos = 0; m_note = '0;
      end
    end else if (m_mode == M_PAUSE) begin
      if (play) m_mode = M_RUN;
    end else if (m_pos == 0) begin
      m_pos = 1;
    end else if (m_pos == 1) begin
      if (rom[m_addr] == END_C) begin
        if (!(loop_en && m_addr != 0)) m_mode = M_IDLE;
        m_addr = 0;
        m_pos  = 0;
      end else begin
        m_note = rom[m_addr];
        m_pos  = 2;
      end
    end else if (play) begin
      m_mode = M_PAUSE;
    end else if (m_pos == int'(BEAT_DIV) + 1) begin
      exp_beat = 1'b1;
      m_addr   = (m_addr + 1) % DEPTH;
      m_pos    = 0;
    end else begin
      m_pos++;
    end

    if (RESET) begin
      exp_note = '0; exp_src = 1'b0;
    end else if (key_valid) begin
      exp_note = key_note; exp_src = 1'b1;
    end else begin
      exp_note = (m_mode == M_RUN) ? m_note : 4'h0;
      exp_src  = 1'b0;
    end
  endtask

  task automatic cycle();
    @(posedge CLK);
    model_update();
    #1;
    chk("rom_addr",   32'(rom_addr),   32'(m_addr));
    chk("note_out",   32'(note_out),   32'(exp_note));
    chk("src_manual", 32'(src_manual), 32'(exp_src));
    chk("busy",       32'(busy),       32'(m_mode != M_IDLE));
    chk("beat",       32'(beat),       32'(exp_beat));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic pulse_play();
    play = 1'b1; cycle(); play = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; cycle(); stop = 1'b0; run(2);
  endtask

  task automatic load_rom(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d);
    rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
  endtask

  initial begin
    load_rom(N_E, N_E, N_F, END_C);
    run(2);
    RESET = 1'b0;
    run(2);

    // Plain playthrough, no loop
    loop_en = 1'b0;
    pulse_play();
    run(24);

    // Looping playthrough
    loop_en = 1'b1;
    pulse_play();
    run(30);
    pulse_stop();

    // Empty song with loop enabled must return to idle
    load_rom(END_C, N_E, N_F, END_C);
    pulse_play();
    run(5);

    // Pause mid-beat with the counter at 2, then resume
    load_rom(N_E, N_E, N_F, END_C);
    pulse_play();
    run(4);
    pulse_play();
    run(20);
    pulse_play();
    run(8);
    pulse_stop();

    // play and stop together while playing
    pulse_play();
    run(3);
    play = 1'b1; stop = 1'b1; cycle(); play = 1'b0; stop = 1'b0;
    run(3);

    // play coinciding with terminal count
    pulse_play();
    run(5);
    pulse_play();
    run(5);
    pulse_play();
    run(6);
    pulse_stop();

    // Live key override and release
    loop_en = 1'b0;
    pulse_play();
    run(3);
    key_valid = 1'b1; key_note = N_G;
    run(4);
    key_valid = 1'b0;
    run(20);

    // No END marker: address wraps 3 -> 0
    load_rom(4'h1, 4'h2, 4'h3, 4'h4);
    pulse_play();
    run(30);
    pulse_stop();

    // Asynchronous reset while playing
    pulse_play();
    run(5);
    #2 RESET = 1'b1;
    #1;
    chk("async_rom_addr", 32'(rom_addr), 32'd0);
    chk("async_note_out", 32'(note_out), 32'd0);
    chk("async_src",      32'(src_manual), 32'd0);
    chk("async_busy",     32'(busy), 32'd0);
    chk("async_beat",     32'(beat), 32'd0);
    cycle();
    RESET = 1'b0;
    run(3);
    pulse_play();
    run(10);
    pulse_stop();

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      play = ($urandom_range(0, 15) == 0);
      stop = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 7) == 0) key_valid = ~key_valid;
      key_note = 4'($urandom);
      if ($urandom_range(0, 49) == 0) loop_en = ~loop_en;
      if (m_mode == M_IDLE && $urandom_range(0, 3) == 0) begin
        for (int a = 0; a < DEPTH; a++)
          rom[a] = ($urandom_range(0, 5) == 0) ? END_C : 4'($urandom_range(0, 14));
      end
      cycle();
    end
    play = 1'b0; stop = 1'b0; key_valid = 1'b0;
    run(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
